// File: rtl/pipe_ctrl_unit.sv
// Main controller for the 5-stage MIPS core: ID decode, ID/EX-EX/MEM-MEM/WB control
// pipeline, load-use stall, branch/jump flush and a saturating bubble counter.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 4,
  parameter int RADDR_W = 5,
  parameter int EN_EXT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode_id,
  input  logic [RADDR_W-1:0] rs_id,
  input  logic [RADDR_W-1:0] rt_id,
  input  logic [RADDR_W-1:0] rd_id,
  input  logic               stall_ext,
  input  logic               branch_taken_ex,
  output logic               id_ext_op,
  output logic               id_jump,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               ifid_flush,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_bne,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [RADDR_W-1:0] ex_wr_addr,
  output logic               ex_illegal,
  output logic               mem_mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [RADDR_W-1:0] wb_wr_addr,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               d_reg_dst, d_branch, d_mem_to_reg, d_alu_src;
  logic               d_mem_write, d_reg_write, d_jump, d_ext, d_bne;
  logic               d_illegal, d_uses_rt;
  logic [3:0]         d_alu_op4;
  logic [RADDR_W-1:0] id_wr_addr;
  logic               id_reg_write;

  logic               ex_mem_to_reg, ex_reg_write, ex_mem_write;
  logic               mem_reg_write, mem_mem_to_reg;
  logic [RADDR_W-1:0] mem_wr_addr;

  logic load_use, flush_br, stall_lu, take_jump, bubble_id;

  // ID stage: opcode decode
  always_comb begin
    d_reg_dst   = 1'b0;
    d_branch    = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_src   = 1'b0;
    d_alu_op4   = 4'b0000;
    d_mem_write = 1'b0;
    d_reg_write = 1'b0;
    d_jump      = 1'b0;
    d_ext       = 1'b0;
    d_bne       = 1'b0;
    d_illegal   = 1'b0;
    d_uses_rt   = 1'b0;
    case (opcode_id)
      6'b000000: begin
        d_reg_dst = 1'b1; d_alu_op4 = 4'b0010; d_reg_write = 1'b1; d_uses_rt = 1'b1;
      end
      6'b001000: begin d_alu_src = 1'b1; d_reg_write = 1'b1; end
      6'b001001: begin d_alu_src = 1'b1; d_reg_write = 1'b1; d_ext = 1'b1; end
      6'b000100: begin d_branch = 1'b1; d_alu_op4 = 4'b0001; d_uses_rt = 1'b1; end
      6'b000010: d_jump = 1'b1;
      6'b100011: begin d_mem_to_reg = 1'b1; d_alu_src = 1'b1; d_reg_write = 1'b1; end
      6'b101011: begin d_alu_src = 1'b1; d_mem_write = 1'b1; d_uses_rt = 1'b1; end
      6'b001111: begin d_alu_src = 1'b1; d_alu_op4 = 4'b0011; d_reg_write = 1'b1; end
      6'b001101: begin d_alu_src = 1'b1; d_alu_op4 = 4'b0100; d_reg_write = 1'b1; end
      6'b000101: begin
        if (EN_EXT != 0) begin
          d_branch = 1'b1; d_bne = 1'b1; d_alu_op4 = 4'b0001; d_uses_rt = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      6'b001100: begin
        if (EN_EXT != 0) begin
          d_alu_src = 1'b1; d_alu_op4 = 4'b0101; d_reg_write = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      6'b001010: begin
        if (EN_EXT != 0) begin
          d_alu_src = 1'b1; d_alu_op4 = 4'b0110; d_reg_write = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Writes to $zero are dropped here so they can never trigger a load-use stall
  assign id_wr_addr   = d_reg_dst ? rd_id : rt_id;
  assign id_reg_write = d_reg_write & (id_wr_addr != '0);

  assign load_use  = ex_mem_to_reg & ex_reg_write &
                     ((ex_wr_addr == rs_id) | (d_uses_rt & (ex_wr_addr == rt_id)));
  assign flush_br  = ~stall_ext & branch_taken_ex;
  assign stall_lu  = ~stall_ext & ~branch_taken_ex & load_use;
  assign take_jump = ~stall_ext & ~branch_taken_ex & ~load_use & d_jump;
  assign bubble_id = flush_br | stall_lu;

  assign pc_stall   = stall_ext | stall_lu;
  assign ifid_stall = stall_ext | stall_lu;
  assign ifid_flush = flush_br | take_jump;
  assign id_jump    = take_jump;
  assign id_ext_op  = d_ext;

  // ID/EX, EX/MEM, MEM/WB registers and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_dst     <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_branch      <= 1'b0;
      ex_bne         <= 1'b0;
      ex_alu_op      <= '0;
      ex_wr_addr     <= '0;
      ex_illegal     <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_write   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_wr_addr    <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_wr_addr     <= '0;
      bubble_cnt     <= '0;
    end else if (!stall_ext) begin
      if (bubble_id) begin
        ex_reg_dst    <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_bne        <= 1'b0;
        ex_alu_op     <= '0;
        ex_wr_addr    <= '0;
        ex_illegal    <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_write  <= 1'b0;
      end else begin
        ex_reg_dst    <= d_reg_dst;
        ex_alu_src    <= d_alu_src;
        ex_branch     <= d_branch;
        ex_bne        <= d_bne;
        ex_alu_op     <= ALUOP_W'(d_alu_op4);
        ex_wr_addr    <= id_wr_addr;
        ex_illegal    <= d_illegal;
        ex_mem_to_reg <= d_mem_to_reg;
        ex_reg_write  <= id_reg_write;
        ex_mem_write  <= d_mem_write;
      end
      mem_mem_write  <= ex_mem_write;
      mem_reg_write  <= ex_reg_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_wr_addr    <= ex_wr_addr;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_wr_addr     <= mem_wr_addr;
      if (stall_lu && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one EN_EXT=1 instance with a narrow counter,
// one EN_EXT=0 instance sharing the same stimulus.
module tb_pipe_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode_id = '0;
  logic [4:0] rs_id = '0, rt_id = '0, rd_id = '0;
  logic       stall_ext = 1'b0, branch_taken_ex = 1'b0;

  logic       id_ext_op, id_jump, pc_stall, ifid_stall, ifid_flush;
  logic       ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_illegal;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_wr_addr, wb_wr_addr;
  logic       mem_mem_write, wb_reg_write, wb_mem_to_reg;
  logic [3:0] bubble_cnt;

  logic       n_id_ext_op, n_id_jump, n_pc_stall, n_ifid_stall, n_ifid_flush;
  logic       n_ex_reg_dst, n_ex_alu_src, n_ex_branch, n_ex_bne, n_ex_illegal;
  logic [3:0] n_ex_alu_op;
  logic [4:0] n_ex_wr_addr, n_wb_wr_addr;
  logic       n_mem_mem_write, n_wb_reg_write, n_wb_mem_to_reg;
  logic [15:0] n_bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
    OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_LUI = 6'b001111, OP_ORI = 6'b001101, OP_BNE = 6'b000101, OP_ANDI = 6'b001100;

  pipe_ctrl_unit #(.ALUOP_W(4), .RADDR_W(5), .EN_EXT(1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_id(rd_id), .stall_ext(stall_ext), .branch_taken_ex(branch_taken_ex),
    .id_ext_op(id_ext_op), .id_jump(id_jump), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .ex_reg_dst(ex_reg_dst),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_bne(ex_bne),
    .ex_alu_op(ex_alu_op), .ex_wr_addr(ex_wr_addr), .ex_illegal(ex_illegal),
    .mem_mem_write(mem_mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_wr_addr(wb_wr_addr), .bubble_cnt(bubble_cnt));

  pipe_ctrl_unit #(.ALUOP_W(4), .RADDR_W(5), .EN_EXT(0), .CNT_W(16)) dut_noext (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_id(rd_id), .stall_ext(stall_ext), .branch_taken_ex(branch_taken_ex),
    .id_ext_op(n_id_ext_op), .id_jump(n_id_jump), .pc_stall(n_pc_stall),
    .ifid_stall(n_ifid_stall), .ifid_flush(n_ifid_flush), .ex_reg_dst(n_ex_reg_dst),
    .ex_alu_src(n_ex_alu_src), .ex_branch(n_ex_branch), .ex_bne(n_ex_bne),
    .ex_alu_op(n_ex_alu_op), .ex_wr_addr(n_ex_wr_addr), .ex_illegal(n_ex_illegal),
    .mem_mem_write(n_mem_mem_write), .wb_reg_write(n_wb_reg_write),
    .wb_mem_to_reg(n_wb_mem_to_reg), .wb_wr_addr(n_wb_wr_addr), .bubble_cnt(n_bubble_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    opcode_id = op; rs_id = rs; rt_id = rt; rd_id = rd;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ex_wr_addr", 32'(ex_wr_addr), 0);
    chk("rst_ex_alu_src", 32'(ex_alu_src), 0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 0);
    rst_n = 1'b1;

    // 1: LW $9 then ADD using $9
    set_id(OP_LW, 5'd0, 5'd9, 5'd0);
    #1 chk("t1_no_stall_yet", 32'(pc_stall), 0);
    tick();
    chk("t1_ex_lw_wr", 32'(ex_wr_addr), 9);
    chk("t1_ex_lw_src", 32'(ex_alu_src), 1);
    set_id(OP_R, 5'd9, 5'd10, 5'd11);
    #1 chk("t1_pc_stall", 32'(pc_stall), 1);
    chk("t1_ifid_stall", 32'(ifid_stall), 1);
    tick();
    chk("t1_bubble_wr", 32'(ex_wr_addr), 0);
    chk("t1_bubble_src", 32'(ex_alu_src), 0);
    chk("t1_bubble_regdst", 32'(ex_reg_dst), 0);
    chk("t1_cnt", 32'(bubble_cnt), 1);
    #1 chk("t1_stall_released", 32'(pc_stall), 0);
    tick();
    chk("t1_ex_add_op", 32'(ex_alu_op), 2);
    chk("t1_ex_add_wr", 32'(ex_wr_addr), 11);
    chk("t1_wb_lw_wr", 32'(wb_wr_addr), 9);
    chk("t1_wb_lw_m2r", 32'(wb_mem_to_reg), 1);
    chk("t1_wb_lw_rw", 32'(wb_reg_write), 1);

    // 2: LW to $0 never stalls a consumer of $0
    set_id(OP_LW, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(OP_R, 5'd0, 5'd0, 5'd5);
    #1 chk("t2_no_stall", 32'(pc_stall), 0);
    tick();
    chk("t2_cnt", 32'(bubble_cnt), 1);

    // 3: taken branch beats a jump in ID; lone jump flushes
    set_id(OP_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    chk("t3_ex_branch", 32'(ex_branch), 1);
    chk("t3_ex_beq_op", 32'(ex_alu_op), 1);
    set_id(OP_J, 5'd3, 5'd4, 5'd5);
    branch_taken_ex = 1'b1;
    #1 chk("t3_flush", 32'(ifid_flush), 1);
    chk("t3_jump_gated", 32'(id_jump), 0);
    chk("t3_pc_run", 32'(pc_stall), 0);
    tick();
    branch_taken_ex = 1'b0;
    chk("t3_bubble_branch", 32'(ex_branch), 0);
    chk("t3_bubble_wr", 32'(ex_wr_addr), 0);
    #1 chk("t3_jump", 32'(id_jump), 1);
    chk("t3_jump_flush", 32'(ifid_flush), 1);
    tick();
    chk("t3_j_illegal", 32'(ex_illegal), 0);
    chk("t3_j_branch", 32'(ex_branch), 0);
    set_id(OP_ADDIU, 5'd1, 5'd2, 5'd0);
    #1 chk("t3_ext_op", 32'(id_ext_op), 1);

    // 4: external freeze for three cycles
    set_id(OP_ADDI, 5'd1, 5'd3, 5'd0);
    tick();
    set_id(OP_SW, 5'd1, 5'd6, 5'd0);
    tick();
    set_id(OP_ORI, 5'd1, 5'd4, 5'd0);
    tick();
    chk("t4_pre_mem_sw", 32'(mem_mem_write), 1);
    set_id(OP_LUI, 5'd0, 5'd7, 5'd0);
    stall_ext = 1'b1;
    #1 chk("t4_pc_stall", 32'(pc_stall), 1);
    chk("t4_no_flush", 32'(ifid_flush), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_ex_wr", 32'(ex_wr_addr), 4);
      chk("t4_hold_ex_op", 32'(ex_alu_op), 4);
      chk("t4_hold_mem", 32'(mem_mem_write), 1);
      chk("t4_hold_wb", 32'(wb_wr_addr), 3);
    end
    stall_ext = 1'b0;
    tick();
    chk("t4_ex_lui_op", 32'(ex_alu_op), 3);
    chk("t4_ex_lui_wr", 32'(ex_wr_addr), 7);
    chk("t4_mem_ori", 32'(mem_mem_write), 0);
    chk("t4_wb_sw_wr", 32'(wb_wr_addr), 6);
    chk("t4_wb_sw_rw", 32'(wb_reg_write), 0);

    // 5: extended opcodes with and without EN_EXT
    set_id(OP_BNE, 5'd1, 5'd2, 5'd0);
    tick();
    chk("t5_bne_branch", 32'(ex_branch), 1);
    chk("t5_bne_flag", 32'(ex_bne), 1);
    chk("t5_bne_illegal", 32'(ex_illegal), 0);
    chk("t5_noext_illegal", 32'(n_ex_illegal), 1);
    chk("t5_noext_branch", 32'(n_ex_branch), 0);
    chk("t5_noext_bne", 32'(n_ex_bne), 0);
    chk("t5_noext_op", 32'(n_ex_alu_op), 0);
    set_id(OP_ANDI, 5'd1, 5'd8, 5'd0);
    tick();
    chk("t5_andi_op", 32'(ex_alu_op), 5);
    chk("t5_noext_andi", 32'(n_ex_illegal), 1);
    set_id(6'b111111, 5'd0, 5'd0, 5'd0);
    tick();
    chk("t5_bad_illegal", 32'(ex_illegal), 1);
    chk("t5_bad_src", 32'(ex_alu_src), 0);

    // 6: counter saturation, then asynchronous reset
    for (int i = 0; i < 18; i++) begin
      set_id(OP_LW, 5'd0, 5'd9, 5'd0);
      tick();
      set_id(OP_R, 5'd9, 5'd10, 5'd11);
      tick();
      if (i == 12) chk("t6_cnt_14", 32'(bubble_cnt), 14);
    end
    chk("t6_cnt_sat", 32'(bubble_cnt), 15);
    set_id(OP_ADDI, 5'd1, 5'd3, 5'd0);
    tick();
    chk("t6_pre_rst_wr", 32'(ex_wr_addr), 3);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_ex_wr", 32'(ex_wr_addr), 0);
    chk("t6_rst_ex_src", 32'(ex_alu_src), 0);
    chk("t6_rst_cnt", 32'(bubble_cnt), 0);
    chk("t6_rst_wb_rw", 32'(wb_reg_write), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
